// File: rtl/rc522_spi_responder_if.sv
// SPI pin bundle between an RC522 reader master and the responder model.
interface rc522_spi_responder_if;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk,
    output mosi,
    output cs_n,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sclk,
    input  mosi,
    input  cs_n,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/rc522_spi_responder.sv
// MFRC522 SPI register-interface responder: 64x8 register file, FIFODataReg FIFO
// and FIFOLevelReg, oversampling the SPI pins on the system clock.
// Optional feature: define RC522_VERSION_REG_EN to make 0x37 a read-only VersionReg.
module rc522_spi_responder #(
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned SYNC_STAGES = 2
`ifdef RC522_VERSION_REG_EN
  , parameter logic [7:0] VERSION = 8'h92
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  rc522_spi_responder_if.slave spi,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  fifo_level,
  output logic        frame_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [5:0] ADDR_FIFO_DATA  = 6'h09;
  localparam logic [5:0] ADDR_FIFO_LEVEL = 6'h0A;
`ifdef RC522_VERSION_REG_EN
  localparam logic [5:0] ADDR_VERSION    = 6'h37;
`endif

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDBURST} state_t;

  state_t                   state;
  logic [2:0]               bit_cnt;
  logic [6:0]               rx_sr;
  logic [7:0]               tx_sr;
  logic [5:0]               addr;
  logic [7:0]               regs [64];
  logic [7:0]               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;

  logic [SYNC_STAGES-1:0]   sclk_sync;
  logic [SYNC_STAGES-1:0]   mosi_sync;
  logic [SYNC_STAGES-1:0]   cs_sync;
  logic                     sclk_d;
  logic                     cs_d;

  logic                     sclk_s, mosi_s, cs_s;
  logic                     sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0]               rx_byte;
  logic [5:0]               rx_addr;
  logic                     byte_done;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop, flush;
  logic                     strobe_en, reg_we, rd_fetch;
  logic [7:0]               fetch_data;

  // Pin synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Edge detects, byte assembly and side-effect decode for the current clk.
  always_comb begin
    sclk_s     = sclk_sync[SYNC_STAGES-1];
    mosi_s     = mosi_sync[SYNC_STAGES-1];
    cs_s       = cs_sync[SYNC_STAGES-1];
    sclk_rise  = sclk_s & ~sclk_d;
    sclk_fall  = ~sclk_s & sclk_d;
    cs_rise    = cs_s & ~cs_d;
    cs_fall    = ~cs_s & cs_d;
    rx_byte    = {rx_sr, mosi_s};
    rx_addr    = rx_byte[6:1];
    byte_done  = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE) && !cs_rise && !cs_fall;
    fifo_full  = (fifo_level == 7'(FIFO_DEPTH));
    fifo_empty = (fifo_level == 7'd0);

    // Read bursts fetch on every byte, whatever its R/W bit.
    rd_fetch   = byte_done && (((state == ADDR) && rx_byte[7]) || (state == RDBURST));

    strobe_en  = byte_done && (state == WDATA);
`ifdef RC522_VERSION_REG_EN
    if (addr == ADDR_VERSION) strobe_en = 1'b0;
`endif
    reg_we     = strobe_en && (addr != ADDR_FIFO_DATA) && (addr != ADDR_FIFO_LEVEL);
    push       = strobe_en && (addr == ADDR_FIFO_DATA) && !fifo_full;
    flush      = strobe_en && (addr == ADDR_FIFO_LEVEL) && rx_byte[7];
    pop        = rd_fetch && (rx_addr == ADDR_FIFO_DATA) && !fifo_empty;

    fetch_data = regs[rx_addr];
    if (rx_addr == ADDR_FIFO_DATA) begin
      fetch_data = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    end else if (rx_addr == ADDR_FIFO_LEVEL) begin
      fetch_data = {1'b0, fifo_level};
    end
`ifdef RC522_VERSION_REG_EN
    else if (rx_addr == ADDR_VERSION) begin
      fetch_data = VERSION;
    end
`endif
  end

  // Frame FSM: shifts mosi in on sclk rise, miso out on sclk fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'd0;
      tx_sr     <= 8'h00;
      addr      <= 6'd0;
      spi.miso    <= 1'b0;
      spi.miso_oe <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 6'd0;
      wr_data   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      wr_strobe   <= 1'b0;
      frame_err   <= 1'b0;
      spi.miso_oe <= ~cs_s;
      if (cs_rise) begin
        frame_err <= (state != IDLE) && (bit_cnt != 3'd0);
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        spi.miso  <= 1'b0;
      end else if (cs_fall) begin
        state    <= ADDR;
        bit_cnt  <= 3'd0;
        tx_sr    <= 8'h00;
        spi.miso <= 1'b0;
      end else if (state == IDLE) begin
        spi.miso <= 1'b0;
      end else if (sclk_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          tx_sr <= 8'h00;
          case (state)
            ADDR: begin
              if (rx_byte[7]) begin
                state <= RDBURST;
                tx_sr <= fetch_data;
              end else begin
                state <= WDATA;
                addr  <= rx_addr;
              end
            end
            WDATA: begin
              if (strobe_en) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= rx_byte;
              end
            end
            RDBURST: tx_sr <= fetch_data;
            default: ;
          endcase
        end
      end else if (sclk_fall) begin
        spi.miso <= tx_sr[7];
        tx_sr    <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  // Register file storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[addr] <= rx_byte;
    end
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_byte;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 7'd0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 7'd0;
    end else if (push) begin
      wr_ptr     <= wr_ptr + PTR_W'(1);
      fifo_level <= fifo_level + 7'd1;
    end else if (pop) begin
      rd_ptr     <= rd_ptr + PTR_W'(1);
      fifo_level <= fifo_level - 7'd1;
    end
  end

endmodule

// File: doc/rc522_spi_responder.md
Name: rc522_spi_responder

Overview:
- SPI-slave model of the MFRC522 register interface: the responder end of the RC522 SPI link driven by the reader's master (sclk/mosi/cs_n/miso).
- Provides a 64 x 8 register file, a FIFO behind FIFODataReg and a FIFO level register.
- Serves as an on-FPGA loopback target and a simulation model for exercising the reader controller without a physical module.
- Runs on the system clock and oversamples the SPI pins.

Parameters:
- FIFO_DEPTH, 64, entries in the FIFODataReg FIFO (power of two, 4..64).
- SYNC_STAGES, 2, synchronizer flops on sclk/mosi/cs_n (2..3).
- VERSION, 8'h92, value returned by VersionReg (optional feature only).

Ports:
- clk  in  1  system clock, at least 8x the sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from master, mode 0 (idle low).
- mosi  in  1  master-out data, MSB first.
- cs_n  in  1  active-low chip select.
- miso  out  1  slave-out data, MSB first.
- miso_oe  out  1  high while cs_n is asserted; the top-level pad tri-states miso when low.
- wr_strobe  out  1  one-clk pulse per completed register write.
- wr_addr  out  6  address of the write being strobed.
- wr_data  out  8  data of the write being strobed.
- fifo_level  out  7  current FIFO occupancy, 0..FIFO_DEPTH.
- frame_err  out  1  one-clk pulse when cs_n rises with a partial byte (bit count not 0).

Behaviour:
- Reset (async):
  - Register file cleared to 0x00; FIFO emptied.
  - All shift/bit counters cleared; state IDLE.
  - miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, fifo_level=0, frame_err=0.
- Synchronization and edge detection:
  - sclk, mosi and cs_n pass through SYNC_STAGES flops.
  - sclk rise/fall are detected on the synchronized signal; all logic runs in the clk domain.
- Framing:
  - A cs_n falling edge (synchronized) enters state ADDR with bit counter 0.
  - mosi is sampled on sclk rising edges; 8 samples form a byte.
  - miso is updated on sclk falling edges (and preloaded on cs_n fall) so it is stable before the next rising edge.
- Address byte format: bit7 = R/W (1 = read); bits6:1 = addr; bit0 ignored.
- States: IDLE, ADDR, WDATA, RDBURST.
  - IDLE -> ADDR on cs_n fall.
  - ADDR -> WDATA when the byte has R/W=0; the address is latched.
  - ADDR -> RDBURST when the byte has R/W=1; the read data for that address is fetched into the shift register.
  - WDATA: every completed byte is written to the latched address; the address does not auto-increment.
  - RDBURST: each received byte is a new address byte. Data for the previous address is shifted out during this byte.
    - Byte N+1 of MISO carries data for the address in byte N.
    - MISO during the first byte is 0x00.
    - If a received byte has R/W=0, it still fetches and is treated as a dummy terminator (a 0x00 byte ends the read).
  - Any state -> IDLE on cs_n rise. A partial byte is discarded: no write, no FIFO push/pop; frame_err pulses if the bit counter != 0.
- Write side effects, taking effect 1 clk after the 8th rising edge:
  - wr_strobe pulses with wr_addr/wr_data.
  - addr 0x09 (FIFODataReg): push; if full, drop the byte, level unchanged.
  - addr 0x0A (FIFOLevelReg): bit7=1 flushes the FIFO; other bits are ignored and the register is not stored.
  - all other addresses: stored in the register file.
- Read side effects:
  - addr 0x09: pop the head; if empty, return 0x00 and leave level at 0.
  - addr 0x0A: returns {1'b0, fifo_level}.
  - others: return the register-file content.
- fifo_level is registered and updates the clk after a push, pop or flush.
- A push and pop in the same clk cannot occur (one SPI byte per event).
- miso_oe follows the synchronized, inverted cs_n. miso is forced to 0 in IDLE.

Optional Feature:
- Macro RC522_VERSION_REG_EN.
- Defined: address 0x37 (VersionReg) reads the constant VERSION. Writes to 0x37 are ignored and do not pulse wr_strobe.
- Undefined: 0x37 is an ordinary read/write register-file location.

Test Plan:
- Write then read:
  - Frame 1: cs_n low, bytes 0x22, 0x5A (write 0x11=0x5A), cs_n high -> wr_strobe once with addr 0x11, data 0x5A.
  - Frame 2: bytes 0xA2, 0x00 -> MISO 0x00, 0x5A.
- FIFO burst write: bytes 0x12, 0x01, 0x02, 0x03 -> fifo_level=3. Reading 0x94 (0x0A) returns 0x03. Read burst 0x92, 0x92, 0x92, 0x00 -> MISO 0x00, 0x01, 0x02, 0x03; fifo_level=0.
- FIFO overflow/underflow:
  - Push FIFO_DEPTH+2 bytes -> level=64, extra bytes dropped.
  - Flush via bytes 0x14, 0x80 -> level=0.
  - Read of 0x09 when empty -> 0x00.
- Aborted frame: cs_n rises after 5 bits of a data byte -> frame_err pulses, no wr_strobe, register unchanged on readback.
- Reset mid-frame: assert rst_n low during a read burst -> miso=0, miso_oe=0, state IDLE, all registers 0x00 on the next frame.
- VersionReg: bytes 0xEE, 0x00 -> MISO second byte 0x92 with RC522_VERSION_REG_EN defined, 0x00 without it. Writing 0x6E, 0x33 then reading back -> 0x92 with the macro defined, 0x33 without it.
